pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and pipeline-sequencing unit for the 5-stage MIPS core. It replaces the fixed two-source forwarding logic with an N-producer scoreboard and resolves rs and rt independently. It adds tracking of a multi-cycle MULT/DIV unit, a configurable branch-flush window and a registered debug halt/step FSM. It drives all per-stage enable and reset strobes.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_fwd_sel.sv | 46 ++++
 rtl/pipeline_hazard_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard / forwarding controller:
//   FWD_RF       forward-select code meaning "use register-file value"
//   dbg_state_e  debug halt/step FSM states
//   fs_width()   width of a forward select covering RF + NPROD producers
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int FWD_RF = 0;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'd0,
    DBG_HALT = 2'd1,
    DBG_STEP = 2'd2
  } dbg_state_e;

  function automatic int fs_width(input int nprod);
    return $clog2(nprod + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// ---------------------------------------------------------------------------
// hazard_fwd_sel
// Priority encoder choosing which producer stage supplies one source operand.
// Producer 0 is the youngest (EXE); the youngest matching producer wins
// because it holds the most recent value of the register.
// Ports:
//   addr_i          operand register address
//   used_i          instruction actually reads this operand
//   prod_wen_i      per-producer write enable
//   prod_addr_i     packed producer destinations, producer i at [i*ADDR_W +: ADDR_W]
//   prod_is_load_i  per-producer load flag
//   sel_o           FWD_RF (0) or producer index + 1
//   hit_is_load_o   winning producer is a load
// ---------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int NPROD  = 3,
  parameter int ADDR_W = 5,
  parameter int FS_W   = fs_width(NPROD)
) (
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic                    used_i,
  input  logic [NPROD-1:0]        prod_wen_i,
  input  logic [NPROD*ADDR_W-1:0] prod_addr_i,
  input  logic [NPROD-1:0]        prod_is_load_i,
  output logic [FS_W-1:0]         sel_o,
  output logic                    hit_is_load_o
);

  // Scan oldest to youngest so the last (lowest-index) match overrides.
  always_comb begin
    sel_o         = FS_W'(FWD_RF);
    hit_is_load_o = 1'b0;
    for (int i = NPROD - 1; i >= 0; i--) begin
      // Register $0 is hard-wired zero and never forwarded.
      if (used_i && prod_wen_i[i] &&
          (prod_addr_i[i*ADDR_W +: ADDR_W] != '0) &&
          (prod_addr_i[i*ADDR_W +: ADDR_W] == addr_i)) begin
        sel_o         = FS_W'(i + 1);
        hit_is_load_o = prod_is_load_i[i];
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard detection, operand forwarding and stage sequencing for the 5-stage
// MIPS core: N-producer forwarding for rs/rt, load-use stall or store-data
// forward, MULT/DIV busy tracking, branch flush window, debug halt/step.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     decoded fields of the instruction in ID
//   prod_wen/addr/is_load    destination info of producers (0 = EXE)
//   branch_taken             taken branch/jump resolved in EXE
//   debug_en, debug_step     halt request level and step request
//   fwd_a, fwd_b, fwd_m      operand / store-data forward selects
//   stall, md_busy           hazard stall, MULT/DIV result pending
//   *_en, *_rst              per-stage enable and reset strobes
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NPROD      = 3,
  parameter int ADDR_W     = 5,
  parameter int MD_LAT     = 4,
  parameter int BR_BUBBLES = 1,
  parameter int FS_W       = fs_width(NPROD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       id_rs_addr,
  input  logic [ADDR_W-1:0]       id_rt_addr,
  input  logic                    id_rs_used,
  input  logic                    id_rt_used,
  input  logic                    id_is_store,
  input  logic                    id_is_md,
  input  logic                    id_reads_hilo,
  input  logic [NPROD-1:0]        prod_wen,
  input  logic [NPROD*ADDR_W-1:0] prod_addr,
  input  logic [NPROD-1:0]        prod_is_load,
  input  logic                    branch_taken,
  input  logic                    debug_en,
  input  logic                    debug_step,
  output logic [FS_W-1:0]         fwd_a,
  output logic [FS_W-1:0]         fwd_b,
  output logic                    fwd_m,
  output logic                    stall,
  output logic                    md_busy,
  output logic                    if_en,
  output logic                    id_en,
  output logic                    exe_en,
  output logic                    mem_en,
  output logic                    wb_en,
  output logic                    if_rst,
  output logic                    id_rst,
  output logic                    exe_rst,
  output logic                    mem_rst,
  output logic                    wb_rst
);

  localparam int MD_W = $clog2(MD_LAT + 1);
  localparam int BR_W = $clog2(BR_BUBBLES + 1);

  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  logic [BR_W-1:0] br_cnt_q, br_cnt_d;
  dbg_state_e      state_q, state_d;
  logic            step_prev_q;

  logic [FS_W-1:0] sel_a, sel_b;
  logic            a_load, b_load;
  logic            lu_a, lu_b, md_stall, data_stall;
  logic            flush, halted, md_accept;

  hazard_fwd_sel #(.NPROD(NPROD), .ADDR_W(ADDR_W), .FS_W(FS_W)) u_sel_rs (
    .addr_i(id_rs_addr), .used_i(id_rs_used), .prod_wen_i(prod_wen),
    .prod_addr_i(prod_addr), .prod_is_load_i(prod_is_load),
    .sel_o(sel_a), .hit_is_load_o(a_load)
  );

  hazard_fwd_sel #(.NPROD(NPROD), .ADDR_W(ADDR_W), .FS_W(FS_W)) u_sel_rt (
    .addr_i(id_rt_addr), .used_i(id_rt_used), .prod_wen_i(prod_wen),
    .prod_addr_i(prod_addr), .prod_is_load_i(prod_is_load),
    .sel_o(sel_b), .hit_is_load_o(b_load)
  );

  assign md_busy = (md_cnt_q != '0);

  // A load in EXE has no data yet: rs must stall; rt of a store can instead
  // pick the loaded word up in MEM via fwd_m.
  assign lu_a       = (sel_a == FS_W'(1)) && a_load;
  assign lu_b       = (sel_b == FS_W'(1)) && b_load;
  assign md_stall   = (id_is_md || id_reads_hilo) && md_busy;
  assign data_stall = lu_a || (lu_b && !id_is_store) || md_stall;
  assign flush      = branch_taken || (br_cnt_q != '0);
  assign halted     = (state_q == DBG_HALT);
  // The ID instruction is wrong-path under a flush, so it never issues.
  assign md_accept  = id_is_md && !halted && !flush && !data_stall;

  // Output strobes, priority: rst > HALT > flush > stall > normal.
  // NOTE: every output gets a default before the if-chain so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    fwd_a   = lu_a ? FS_W'(FWD_RF) : sel_a;
    fwd_b   = lu_b ? FS_W'(FWD_RF) : sel_b;
    fwd_m   = lu_b && id_is_store;
    stall   = 1'b0;
    if_en   = 1'b1;
    id_en   = 1'b1;
    exe_en  = 1'b1;
    mem_en  = 1'b1;
    wb_en   = 1'b1;
    if_rst  = 1'b0;
    id_rst  = 1'b0;
    exe_rst = 1'b0;
    mem_rst = 1'b0;
    wb_rst  = 1'b0;
    if (rst) begin
      fwd_a   = FS_W'(FWD_RF);
      fwd_b   = FS_W'(FWD_RF);
      fwd_m   = 1'b0;
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (halted) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else if (flush) begin
      id_rst = 1'b1;
    end else if (data_stall) begin
      stall   = 1'b1;
      if_en   = 1'b0;
      id_en   = 1'b0;
      exe_rst = 1'b1;
    end
  end

  // Counters and debug FSM next state.
  always_comb begin
    md_cnt_d = md_cnt_q;
    br_cnt_d = br_cnt_q;
    state_d  = state_q;

    if (md_accept)                     md_cnt_d = MD_W'(MD_LAT);
    else if (!halted && md_cnt_q != '0) md_cnt_d = md_cnt_q - 1'b1;

    if (!halted) begin
      if (branch_taken)           br_cnt_d = BR_W'(BR_BUBBLES - 1);
      else if (br_cnt_q != '0)    br_cnt_d = br_cnt_q - 1'b1;
    end

    unique case (state_q)
      DBG_RUN:  if (debug_en) state_d = DBG_HALT;
      DBG_HALT: begin
        if (!debug_en)                      state_d = DBG_RUN;
        else if (debug_step && !step_prev_q) state_d = DBG_STEP;
      end
      DBG_STEP: state_d = debug_en ? DBG_HALT : DBG_RUN;
      default:  state_d = DBG_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q    <= '0;
      br_cnt_q    <= '0;
      state_q     <= DBG_RUN;
      step_prev_q <= 1'b0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      br_cnt_q    <= br_cnt_d;
      state_q     <= state_d;
      step_prev_q <= debug_step;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl (NPROD=3, MD_LAT=4, BR_BUBBLES=2).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// Strobe vectors are packed {if, id, exe, mem, wb}.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int NPROD      = 3;
  localparam int ADDR_W     = 5;
  localparam int MD_LAT     = 4;
  localparam int BR_BUBBLES = 2;
  localparam int FS_W       = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [ADDR_W-1:0]       id_rs_addr, id_rt_addr;
  logic                    id_rs_used, id_rt_used;
  logic                    id_is_store, id_is_md, id_reads_hilo;
  logic [NPROD-1:0]        prod_wen, prod_is_load;
  logic [NPROD*ADDR_W-1:0] prod_addr;
  logic                    branch_taken, debug_en, debug_step;
  logic [FS_W-1:0]         fwd_a, fwd_b;
  logic                    fwd_m, stall, md_busy;
  logic                    if_en, id_en, exe_en, mem_en, wb_en;
  logic                    if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic [4:0]              en_v, rst_v;

  assign en_v  = {if_en, id_en, exe_en, mem_en, wb_en};
  assign rst_v = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};

  pipeline_hazard_ctrl #(
    .NPROD(NPROD), .ADDR_W(ADDR_W), .MD_LAT(MD_LAT),
    .BR_BUBBLES(BR_BUBBLES), .FS_W(FS_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_store(id_is_store), .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo),
    .prod_wen(prod_wen), .prod_addr(prod_addr), .prod_is_load(prod_is_load),
    .branch_taken(branch_taken), .debug_en(debug_en), .debug_step(debug_step),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_m(fwd_m), .stall(stall), .md_busy(md_busy),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst),
    .wb_rst(wb_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs_addr    = '0;
    id_rt_addr    = '0;
    id_rs_used    = 1'b0;
    id_rt_used    = 1'b0;
    id_is_store   = 1'b0;
    id_is_md      = 1'b0;
    id_reads_hilo = 1'b0;
    prod_wen      = '0;
    prod_addr     = '0;
    prod_is_load  = '0;
    branch_taken  = 1'b0;
    debug_en      = 1'b0;
    debug_step    = 1'b0;
  endtask

  task automatic set_prod(input int i, input logic wen, input logic [ADDR_W-1:0] a,
                          input logic ld);
    prod_wen[i]                 = wen;
    prod_addr[i*ADDR_W +: ADDR_W] = a;
    prod_is_load[i]             = ld;
  endtask

  task automatic set_id(input logic [ADDR_W-1:0] rs, input logic rs_u,
                        input logic [ADDR_W-1:0] rt, input logic rt_u);
    id_rs_addr = rs;
    id_rs_used = rs_u;
    id_rt_addr = rt;
    id_rt_used = rt_u;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    check("reset_rst", rst_v, 5'b11111);
    check("reset_en", en_v, 5'b11111);
    check("reset_fwd_a", fwd_a, 0);
    check("reset_fwd_b", fwd_b, 0);
    check("reset_fwd_m", fwd_m, 0);
    check("reset_stall", stall, 0);
    check("reset_md_busy", md_busy, 0);
    next_cycle();
    rst = 1'b0;

    // Chained forwarding: add $3 in EXE, add $4 in MEM, older $3 in WB.
    next_cycle();
    set_prod(0, 1, 5'd3, 0);
    set_prod(1, 1, 5'd4, 0);
    set_prod(2, 1, 5'd3, 0);
    set_id(5'd3, 1, 5'd4, 1);
    #1;
    check("chain_fwd_a", fwd_a, 1);
    check("chain_fwd_b", fwd_b, 2);
    check("chain_stall", stall, 0);
    check("chain_en", en_v, 5'b11111);
    check("chain_rst", rst_v, 5'b00000);
    set_prod(0, 1, 5'd9, 0);
    set_id(5'd4, 1, 5'd4, 1);
    #1;
    check("both_mem_fwd_a", fwd_a, 2);
    check("both_mem_fwd_b", fwd_b, 2);
    set_id(5'd4, 0, 5'd3, 1);
    #1;
    check("unused_fwd_a", fwd_a, 0);
    check("wb_fwd_b", fwd_b, 3);

    // Load-use: lw $2 in EXE.
    next_cycle();
    clear_inputs();
    set_prod(0, 1, 5'd2, 1);
    set_id(5'd2, 1, 5'd1, 1);
    #1;
    check("lu_rs_stall", stall, 1);
    check("lu_rs_en", en_v, 5'b00111);
    check("lu_rs_rst", rst_v, 5'b00100);
    set_id(5'd7, 1, 5'd2, 1);
    id_is_store = 1'b1;
    #1;
    check("lu_sw_fwd_m", fwd_m, 1);
    check("lu_sw_stall", stall, 0);
    check("lu_sw_fwd_b", fwd_b, 0);
    check("lu_sw_en", en_v, 5'b11111);
    id_is_store = 1'b0;
    #1;
    check("lu_rt_stall", stall, 1);
    check("lu_rt_fwd_m", fwd_m, 0);

    // Load in MEM forwards normally.
    next_cycle();
    clear_inputs();
    set_prod(1, 1, 5'd2, 1);
    set_id(5'd2, 1, 5'd2, 1);
    #1;
    check("ld_mem_fwd_a", fwd_a, 2);
    check("ld_mem_fwd_b", fwd_b, 2);
    check("ld_mem_stall", stall, 0);

    // Register zero never forwards or stalls.
    next_cycle();
    clear_inputs();
    set_prod(0, 1, 5'd0, 1);
    set_id(5'd0, 1, 5'd0, 1);
    #1;
    check("r0_fwd_a", fwd_a, 0);
    check("r0_fwd_b", fwd_b, 0);
    check("r0_stall", stall, 0);

    // MULT/DIV: issue, then mfhi waits MD_LAT cycles.
    next_cycle();
    clear_inputs();
    id_is_md = 1'b1;
    #1;
    check("md_issue_busy", md_busy, 0);
    check("md_issue_stall", stall, 0);
    next_cycle();
    id_is_md      = 1'b0;
    id_reads_hilo = 1'b1;
    for (int k = 0; k < MD_LAT; k++) begin
      #1;
      check($sformatf("md_busy_c%0d", k + 1), md_busy, 1);
      check($sformatf("mfhi_stall_c%0d", k + 1), stall, 1);
      check($sformatf("mfhi_en_c%0d", k + 1), en_v, 5'b00111);
      next_cycle();
    end
    #1;
    check("md_done_busy", md_busy, 0);
    check("mfhi_go_stall", stall, 0);

    // Branch overrides a load-use stall; MULT/DIV on wrong path not taken.
    next_cycle();
    clear_inputs();
    set_prod(0, 1, 5'd2, 1);
    set_id(5'd2, 1, 5'd0, 0);
    branch_taken = 1'b1;
    id_is_md     = 1'b1;
    #1;
    check("br0_stall", stall, 0);
    check("br0_rst", rst_v, 5'b01000);
    check("br0_en", en_v, 5'b11111);
    next_cycle();
    branch_taken = 1'b0;
    id_is_md     = 1'b0;
    #1;
    check("br1_rst", rst_v, 5'b01000);
    check("br1_stall", stall, 0);
    check("br1_md_busy", md_busy, 0);
    next_cycle();
    #1;
    check("br2_rst", rst_v, 5'b00100);
    check("br2_stall", stall, 1);

    // Branch reload while the window is open.
    next_cycle();
    clear_inputs();
    branch_taken = 1'b1;
    next_cycle();
    #1;
    check("reload0_rst", rst_v, 5'b01000);
    next_cycle();
    branch_taken = 1'b0;
    #1;
    check("reload1_rst", rst_v, 5'b01000);
    next_cycle();
    #1;
    check("reload2_rst", rst_v, 5'b00000);

    // Debug halt / single step, MULT/DIV counter frozen in HALT.
    next_cycle();
    clear_inputs();
    id_is_md = 1'b1;
    debug_en = 1'b1;
    #1;
    check("dbg_run_en", en_v, 5'b11111);
    next_cycle();
    id_is_md = 1'b0;
    #1;
    check("halt_en", en_v, 5'b00000);
    check("halt_rst", rst_v, 5'b00000);
    check("halt_md_busy", md_busy, 1);
    next_cycle();
    next_cycle();
    #1;
    check("halt3_en", en_v, 5'b00000);
    check("halt3_md_busy", md_busy, 1);
    debug_step = 1'b1;
    next_cycle();
    #1;
    check("step_en", en_v, 5'b11111);
    next_cycle();
    #1;
    check("post_step_en", en_v, 5'b00000);
    next_cycle();
    #1;
    check("held_step_en", en_v, 5'b00000);
    debug_en = 1'b0;
    next_cycle();
    #1;
    check("resume_en", en_v, 5'b11111);
    check("resume_md_busy", md_busy, 1);
    debug_step = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    check("frozen_cnt_busy", md_busy, 1);
    next_cycle();
    #1;
    check("frozen_cnt_done", md_busy, 0);
    debug_step = 1'b1;
    next_cycle();
    #1;
    check("run_step_ignored", en_v, 5'b11111);
    debug_step = 1'b0;

    // Reset mid-operation.
    next_cycle();
    clear_inputs();
    id_is_md = 1'b1;
    next_cycle();
    id_is_md = 1'b0;
    #1;
    check("pre_rst_md_busy", md_busy, 1);
    rst = 1'b1;
    set_prod(0, 1, 5'd2, 1);
    set_id(5'd2, 1, 5'd0, 0);
    #1;
    check("midrst_rst", rst_v, 5'b11111);
    check("midrst_en", en_v, 5'b11111);
    check("midrst_stall", stall, 0);
    check("midrst_fwd_a", fwd_a, 0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("post_rst_md_busy", md_busy, 0);
    check("post_rst_stall", stall, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
